// File: rtl/frame_scanout_if.sv
// Frame-scanout bus: frame-buffer read port, buffer-swap handshake and VGA outputs.
interface frame_scanout_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W:0] fb_rd_addr;
    logic [7:0]      fb_rd_data;
    logic            swap_req;
    logic            swap_ack;
    logic            front_buf;
    logic [2:0]      vga_r;
    logic [2:0]      vga_g;
    logic [1:0]      vga_b;
    logic            vga_hsync;
    logic            vga_vsync;
    logic            frame_start;

    // Scanout engine side
    modport master (
        output fb_rd_addr,
        input  fb_rd_data,
        input  swap_req,
        output swap_ack,
        output front_buf,
        output vga_r,
        output vga_g,
        output vga_b,
        output vga_hsync,
        output vga_vsync,
        output frame_start
    );

    // Frame-buffer / display side
    modport slave (
        input  fb_rd_addr,
        output fb_rd_data,
        output swap_req,
        input  swap_ack,
        input  front_buf,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vga_hsync,
        input  vga_vsync,
        input  frame_start
    );
endinterface

// File: rtl/frame_scanout.sv
// Double-buffered VGA scanout: raster counters, 3-stage read/output pipeline
// with pixel replication, and a frame-synchronous front/back buffer swap.
//
// Swap FSM states:
//   ARMED        | a pending swap_req is honoured at the next swap boundary
//   WAIT_RELEASE | swap done, waiting for swap_req to drop before re-arming
module frame_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SCALE    = 4,
    parameter int ADDR_W   = 15
) (
    input logic            clk,
    input logic            rst,
    frame_scanout_if.master bus
);
    localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int  FB_W       = H_ACTIVE / SCALE;
    localparam int  HW         = $clog2(H_TOTAL);
    localparam int  VW         = $clog2(V_TOTAL);
    localparam int  SCALE_SH   = $clog2(SCALE);
    localparam bit  SCALE_POW2 = ((SCALE & (SCALE - 1)) == 0);

    typedef enum logic {ARMED, WAIT_RELEASE} swap_state_t;

    logic [HW-1:0]     h_cnt_q, h_cnt_d;
    logic [VW-1:0]     v_cnt_q, v_cnt_d;
    logic [HW-1:0]     h_div;
    logic [VW-1:0]     v_div;
    logic [ADDR_W-1:0] pix_idx;
    logic              act_s0, hs_s0, vs_s0, first_s0, boundary;

    logic [ADDR_W:0]   addr_q;
    logic              act1_q, hs1_q, vs1_q, fs1_q;
    logic              act2_q, hs2_q, vs2_q, fs2_q;
    logic [7:0]        rgb_q;
    logic              hsync_q, vsync_q, fstart_q;

    swap_state_t       state_q;
    logic              front_q, ack_q;

    // Counter next-state and stage-0 decode of the raster position
    always_comb begin
        h_cnt_d = (h_cnt_q == HW'(H_TOTAL - 1)) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HW'(H_TOTAL - 1))
            v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;

        act_s0   = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
        hs_s0    = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                   (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_s0    = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                   (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
        first_s0 = (h_cnt_q == '0) && (v_cnt_q == '0);
        boundary = (h_cnt_q == HW'(H_TOTAL - 1)) && (v_cnt_q == VW'(V_ACTIVE - 1));

        // Constant-folded: shift for power-of-two replication, divide otherwise
        if (SCALE_POW2) begin
            h_div = h_cnt_q >> SCALE_SH;
            v_div = v_cnt_q >> SCALE_SH;
        end else begin
            h_div = h_cnt_q / HW'(SCALE);
            v_div = v_cnt_q / VW'(SCALE);
        end
        // Blanking reads index 0 so the address bus stays quiet outside the picture
        pix_idx = act_s0 ? ADDR_W'(32'(v_div) * 32'(FB_W) + 32'(h_div)) : '0;
    end

    // Raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Read address, flag delay line and output registers (3 clk counter-to-pin)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            act1_q   <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            fs1_q    <= 1'b0;
            act2_q   <= 1'b0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            fs2_q    <= 1'b0;
            rgb_q    <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            fstart_q <= 1'b0;
        end else begin
            addr_q   <= {front_q, pix_idx};
            act1_q   <= act_s0;
            hs1_q    <= hs_s0;
            vs1_q    <= vs_s0;
            fs1_q    <= first_s0;
            act2_q   <= act1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            fs2_q    <= fs1_q;
            rgb_q    <= act2_q ? bus.fb_rd_data : 8'h00;
            hsync_q  <= ~hs2_q;
            vsync_q  <= ~vs2_q;
            fstart_q <= fs2_q;
        end
    end

    // Swap FSM: toggle front buffer only at the end of the last active line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARMED;
            front_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ARMED: begin
                    if (bus.swap_req && boundary) begin
                        front_q <= ~front_q;
                        ack_q   <= 1'b1;
                        state_q <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!bus.swap_req)
                        state_q <= ARMED;
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign bus.fb_rd_addr  = addr_q;
    assign bus.vga_r       = rgb_q[7:5];
    assign bus.vga_g       = rgb_q[4:2];
    assign bus.vga_b       = rgb_q[1:0];
    assign bus.vga_hsync   = hsync_q;
    assign bus.vga_vsync   = vsync_q;
    assign bus.frame_start = fstart_q;
    assign bus.swap_ack    = ack_q;
    assign bus.front_buf   = front_q;
endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout on a reduced raster (48x24 total, 32x16 active,
// SCALE 4 -> 8x4 frame buffer) so that several full frames fit in a short run.
// Cycle k = number of rising edges since reset release; counter value in
// cycle k is k, address reflects k-1, pins reflect k-3.
module tb_frame_scanout;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic const_mode = 1'b1;
    int   cyc;
    int   ack_cnt;
    int   n_assert = 0;
    int   n_fail   = 0;

    frame_scanout_if #(.ADDR_W(AW)) bus ();

    frame_scanout #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SCALE(4), .ADDR_W(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame buffer: constant E3 or data = address
    always @(posedge clk)
        bus.fb_rd_data <= const_mode ? 8'hE3 : {2'b00, bus.fb_rd_addr};

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;

    always @(negedge clk or posedge rst)
        if (rst)               ack_cnt <= 0;
        else if (bus.swap_ack) ack_cnt <= ack_cnt + 1;

    typedef struct {
        int         cyc;
        bit         chk_out;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
        logic       fs;
        bit         chk_addr;
        logic [5:0] addr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard = 0;
        while (cyc < k) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 20000) begin
                $display("FAIL wait_cyc timeout cyc=%0d target=%0d", cyc, k);
                $fatal(1, "timeout");
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] cur_rgb();
        return {bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    task automatic add_out(input int k, input logic [7:0] rgb, input logic hs,
                           input logic vs, input logic fs);
        vecs.push_back('{k, 1'b1, rgb, hs, vs, fs, 1'b0, 6'd0});
    endtask

    task automatic add_addr(input int k, input logic [5:0] a);
        vecs.push_back('{k, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, a});
    endtask

    initial begin
        int hs_low, vs_low, fs_cnt, pix_cnt;
        bus.swap_req = 1'b0;

        // Output rows: cycle, rgb, hsync, vsync, frame_start
        add_out(2,    8'h00, 1, 1, 0);
        add_out(3,    8'hE3, 1, 1, 1);
        add_out(4,    8'hE3, 1, 1, 0);
        add_out(34,   8'hE3, 1, 1, 0);
        add_out(35,   8'h00, 1, 1, 0);
        add_out(38,   8'h00, 1, 1, 0);
        add_out(39,   8'h00, 0, 1, 0);
        add_out(44,   8'h00, 0, 1, 0);
        add_out(45,   8'h00, 1, 1, 0);
        add_out(51,   8'hE3, 1, 1, 0);
        add_out(754,  8'hE3, 1, 1, 0);
        add_out(771,  8'h00, 1, 1, 0);
        add_out(866,  8'h00, 1, 1, 0);
        add_out(867,  8'h00, 1, 0, 0);
        add_out(903,  8'h00, 0, 0, 0);
        add_out(962,  8'h00, 1, 0, 0);
        add_out(963,  8'h00, 1, 1, 0);
        add_out(1154, 8'h00, 1, 1, 0);
        add_out(1155, 8'hE3, 1, 1, 1);
        // Address rows: cycle, {front_buf, index}
        add_addr(1,   6'd0);
        add_addr(6,   6'd1);
        add_addr(248, 6'd9);
        add_addr(397, 6'd19);
        add_addr(752, 6'd31);
        add_addr(753, 6'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr",  32'(bus.fb_rd_addr), 0);
        chk("rst_rgb",   32'(cur_rgb()), 0);
        chk("rst_hsync", 32'(bus.vga_hsync), 1);
        chk("rst_vsync", 32'(bus.vga_vsync), 1);
        chk("rst_ack",   32'(bus.swap_ack), 0);
        chk("rst_fs",    32'(bus.frame_start), 0);
        chk("rst_front", 32'(bus.front_buf), 0);

        // Table-driven raster check over one full frame, constant pixel
        const_mode = 1'b1;
        do_reset();
        hs_low = 0; vs_low = 0; fs_cnt = 0; pix_cnt = 0;
        for (int k = 0; k <= 1155; k++) begin
            wait_cyc(k);
            foreach (vecs[i]) begin
                if (vecs[i].cyc == k) begin
                    if (vecs[i].chk_out) begin
                        chk($sformatf("vec%0d_rgb", i), 32'(cur_rgb()), 32'(vecs[i].rgb));
                        chk($sformatf("vec%0d_hs", i), 32'(bus.vga_hsync), 32'(vecs[i].hs));
                        chk($sformatf("vec%0d_vs", i), 32'(bus.vga_vsync), 32'(vecs[i].vs));
                        chk($sformatf("vec%0d_fs", i), 32'(bus.frame_start), 32'(vecs[i].fs));
                    end
                    if (vecs[i].chk_addr)
                        chk($sformatf("vec%0d_addr", i), 32'(bus.fb_rd_addr), 32'(vecs[i].addr));
                end
            end
            if (k >= 3 && k <= 1154) begin
                if (!bus.vga_hsync)       hs_low++;
                if (!bus.vga_vsync)       vs_low++;
                if (bus.frame_start)      fs_cnt++;
                if (cur_rgb() == 8'hE3)   pix_cnt++;
            end
        end
        chk("frame_hs_low",  32'(hs_low), 144);
        chk("frame_vs_low",  32'(vs_low), 96);
        chk("frame_fs_cnt",  32'(fs_cnt), 1);
        chk("frame_pix_cnt", 32'(pix_cnt), 512);

        // Held swap_req: one swap, none while held, swap back after re-arm
        const_mode = 1'b0;
        do_reset();
        wait_cyc(300);  bus.swap_req = 1'b1;
        wait_cyc(767);  chk("s1_pre_front", 32'(bus.front_buf), 0);
                        chk("s1_pre_ack",   32'(bus.swap_ack), 0);
        wait_cyc(768);  chk("s1_ack",       32'(bus.swap_ack), 1);
                        chk("s1_front",     32'(bus.front_buf), 1);
        wait_cyc(769);  chk("s1_ack_pulse", 32'(bus.swap_ack), 0);
        wait_cyc(1153); chk("s1_addr00",    32'(bus.fb_rd_addr), 32);
        wait_cyc(1155); chk("s1_rgb00",     32'(cur_rgb()), 32'h20);
        wait_cyc(1400); chk("s1_addr75",    32'(bus.fb_rd_addr), 41);
        wait_cyc(1402); chk("s1_rgb75",     32'(cur_rgb()), 32'h29);
        wait_cyc(1920); chk("s1_held_ack",  32'(bus.swap_ack), 0);
                        chk("s1_held_front",32'(bus.front_buf), 1);
        wait_cyc(2000); bus.swap_req = 1'b0;
        wait_cyc(2100); bus.swap_req = 1'b1;
        wait_cyc(3072); chk("s1_back_ack",  32'(bus.swap_ack), 1);
                        chk("s1_back_front",32'(bus.front_buf), 0);
        wait_cyc(3074); chk("s1_ack_cnt",   32'(ack_cnt), 2);
        bus.swap_req = 1'b0;

        // Single-clk request exactly at the boundary, then one clk late
        do_reset();
        wait_cyc(767);  bus.swap_req = 1'b1;
        wait_cyc(768);  bus.swap_req = 1'b0;
                        chk("s2_edge_ack",   32'(bus.swap_ack), 1);
                        chk("s2_edge_front", 32'(bus.front_buf), 1);
        wait_cyc(1920); bus.swap_req = 1'b1;
        wait_cyc(1921); chk("s2_late_ack",   32'(bus.swap_ack), 0);
                        chk("s2_late_front", 32'(bus.front_buf), 1);
        wait_cyc(3071); chk("s2_defer_front",32'(bus.front_buf), 1);
        wait_cyc(3072); chk("s2_defer_ack",  32'(bus.swap_ack), 1);
                        chk("s2_defer_front2",32'(bus.front_buf), 0);
        bus.swap_req = 1'b0;

        // Asynchronous reset mid-line with front_buf=1 and FSM in WAIT_RELEASE
        do_reset();
        bus.swap_req = 1'b1;
        wait_cyc(1162); chk("r_pre_front", 32'(bus.front_buf), 1);
                        chk("r_pre_rgb",   32'(cur_rgb()), 32'h21);
        #2 rst = 1'b1;
        #1;
        chk("r_addr",  32'(bus.fb_rd_addr), 0);
        chk("r_rgb",   32'(cur_rgb()), 0);
        chk("r_hsync", 32'(bus.vga_hsync), 1);
        chk("r_vsync", 32'(bus.vga_vsync), 1);
        chk("r_front", 32'(bus.front_buf), 0);
        chk("r_ack",   32'(bus.swap_ack), 0);
        chk("r_fs",    32'(bus.frame_start), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(1);   chk("r_addr00",  32'(bus.fb_rd_addr), 0);
        wait_cyc(2);   chk("r_fs2",     32'(bus.frame_start), 0);
        wait_cyc(3);   chk("r_fs3",     32'(bus.frame_start), 1);
        wait_cyc(768); chk("r_rearm_ack",   32'(bus.swap_ack), 1);
                       chk("r_rearm_front", 32'(bus.front_buf), 1);
        bus.swap_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
